// File: rtl/cpu_flash_ctrl.sv
// rtl/cpu_flash_ctrl.sv - CPU bus to flash bridge with byte-granular RMW writes and per-phase timeout
// Optional one-entry read cache enabled by defining FLASH_READ_CACHE_EN.
module cpu_flash_ctrl #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bus_request,
  input  logic [DATA_W/8-1:0] bus_wmask,
  input  logic [ADDR_W-1:0]   bus_address,
  input  logic [DATA_W-1:0]   bus_wdata,
  output logic                bus_ack,
  output logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_error,
  output logic                flash_request,
  output logic                flash_write,
  output logic [ADDR_W-1:0]   flash_address,
  output logic [DATA_W-1:0]   flash_wdata,
  input  logic                flash_ack,
  input  logic [DATA_W-1:0]   flash_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t            state;
  logic [NB-1:0]     wmask_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     cnt;
  logic              expired;
  logic [ADDR_W-1:0] aligned;

  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign aligned = bus_address & ~ADDR_W'(NB - 1);

`ifdef FLASH_READ_CACHE_EN
  logic              cache_valid;
  logic [ADDR_W-1:0] cache_tag;
  logic [DATA_W-1:0] cache_data;
  logic              hit_q;
  logic              hit;

  assign hit = cache_valid && (cache_tag == aligned);
`endif

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [NB-1:0]     mask);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (mask[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wmask_q       <= '0;
      wdata_q       <= '0;
      cnt           <= '0;
      bus_ack       <= 1'b0;
      bus_error     <= 1'b0;
      bus_rdata     <= '0;
      flash_request <= 1'b0;
      flash_write   <= 1'b0;
      flash_address <= '0;
      flash_wdata   <= '0;
`ifdef FLASH_READ_CACHE_EN
      cache_valid   <= 1'b0;
      cache_tag     <= '0;
      cache_data    <= '0;
      hit_q         <= 1'b0;
`endif
    end else begin
      bus_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus_request) begin
            wmask_q       <= bus_wmask;
            wdata_q       <= bus_wdata;
            flash_address <= aligned;
            cnt           <= '0;
            bus_error     <= 1'b0;
            if (bus_wmask == '0) begin
              state       <= RD;
              flash_write <= 1'b0;
`ifdef FLASH_READ_CACHE_EN
              hit_q         <= hit;
              flash_request <= !hit;
`else
              flash_request <= 1'b1;
`endif
            end else if (&bus_wmask) begin
              state         <= WR;
              flash_write   <= 1'b1;
              flash_wdata   <= bus_wdata;
              flash_request <= 1'b1;
            end else begin
              state         <= RMW_RD;
              flash_write   <= 1'b0;
              flash_request <= 1'b1;
            end
          end
        end

        RD: begin
`ifdef FLASH_READ_CACHE_EN
          if (hit_q) begin
            hit_q     <= 1'b0;
            bus_rdata <= cache_data;
            bus_ack   <= 1'b1;
            state     <= RESP;
          end else
`endif
          if (flash_ack) begin
            flash_request <= 1'b0;
            bus_rdata     <= flash_rdata;
            bus_ack       <= 1'b1;
            state         <= RESP;
`ifdef FLASH_READ_CACHE_EN
            cache_valid   <= 1'b1;
            cache_tag     <= flash_address;
            cache_data    <= flash_rdata;
`endif
          end else if (expired) begin
            flash_request <= 1'b0;
            bus_error     <= 1'b1;
            bus_rdata     <= '1;
            bus_ack       <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RMW_RD: begin
          if (flash_ack) begin
            // request drops here; WR re-raises it on its first cycle
            flash_request <= 1'b0;
            flash_write   <= 1'b1;
            flash_wdata   <= merge(flash_rdata, wdata_q, wmask_q);
            state         <= WR;
          end else if (expired) begin
            flash_request <= 1'b0;
            bus_error     <= 1'b1;
            bus_rdata     <= '1;
            bus_ack       <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WR: begin
          if (!flash_request) begin
            flash_request <= 1'b1;
            cnt           <= '0;
          end else if (flash_ack) begin
            flash_request <= 1'b0;
            bus_rdata     <= flash_wdata;
            bus_ack       <= 1'b1;
            state         <= RESP;
`ifdef FLASH_READ_CACHE_EN
            if (cache_valid && (cache_tag == flash_address)) cache_data <= flash_wdata;
`endif
          end else if (expired) begin
            flash_request <= 1'b0;
            bus_error     <= 1'b1;
            bus_rdata     <= '1;
            bus_ack       <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RESP: begin
          bus_error <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
